// File: rtl/color_sensor_sequencer.sv
// Colour-sensor measurement sequencer: drives scaling and filter pins,
// counts synchronised freq_in edges per colour and publishes four results.
module color_sensor_sequencer #(
    parameter int GATE_CYCLES   = 1000,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             abort,
    input  logic             freq_in,
    output logic             s0,
    output logic             s1,
    output logic             s2,
    output logic             s3,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] blue_cnt,
    output logic [CNT_W-1:0] clear_cnt
);

    localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_GATE,
        ST_STORE,
        ST_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [TW-1:0]    r_tmr;
    logic [1:0]       r_idx;
    logic [1:0]       r_mode_q;
    logic [1:0]       r_filt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic [1:0]       r_sync;
    logic             r_prev;
    logic             w_edge;
    logic             w_go;
    logic             w_settle_end;
    logic             w_gate_end;

    // Filter code for colour index: red, green, blue, clear.
    function automatic logic [1:0] f_code(input logic [1:0] idx);
        logic [1:0] c;
        unique case (idx)
            2'd0: c = 2'b00;
            2'd1: c = 2'b11;
            2'd2: c = 2'b01;
            default: c = 2'b10;
        endcase
        return c;
    endfunction

    assign w_edge       = r_sync[1] & ~r_prev;
    assign w_go         = start & (mode != 2'b00) & ~abort;
    assign w_settle_end = (r_tmr == TW'(SETTLE_CYCLES - 1));
    assign w_gate_end   = (r_tmr == TW'(GATE_CYCLES - 1));

    // Two-flop synchroniser and rising-edge history for freq_in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], freq_in};
            r_prev <= r_sync[1];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic and pin/status decode.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_go) w_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (abort)             w_next = ST_IDLE;
                else if (w_settle_end) w_next = ST_GATE;
            end
            ST_GATE: begin
                busy = 1'b1;
                if (abort)           w_next = ST_IDLE;
                else if (w_gate_end) w_next = ST_STORE;
            end
            ST_STORE: begin
                busy = 1'b1;
                if (abort)              w_next = ST_IDLE;
                else if (r_idx == 2'd3) w_next = ST_DONE;
                else                    w_next = ST_SETTLE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        {s0, s1} = busy ? r_mode_q : 2'b00;
        {s2, s3} = r_filt;
        overflow = r_ovf;
    end

    // Phase timer, colour index, latched mode, edge counter and overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr    <= '0;
            r_idx    <= 2'd0;
            r_mode_q <= 2'b00;
            r_filt   <= 2'b00;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if ((r_state == ST_SETTLE || r_state == ST_GATE) && w_next == r_state)
                r_tmr <= r_tmr + TW'(1);
            else
                r_tmr <= '0;
            if (r_state == ST_IDLE && w_go) begin
                r_mode_q <= mode;
                r_ovf    <= 1'b0;
                r_idx    <= 2'd0;
                r_filt   <= f_code(2'd0);
            end
            if (r_state == ST_STORE && !abort && r_idx != 2'd3) begin
                r_idx  <= r_idx + 2'd1;
                r_filt <= f_code(r_idx + 2'd1);
            end
            if (r_state == ST_SETTLE) begin
                r_cnt <= '0;
            end else if (r_state == ST_GATE && w_edge) begin
                if (r_cnt == {CNT_W{1'b1}}) r_ovf <= 1'b1;
                else                        r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Result registers, written only in their own colour's store cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_cnt   <= '0;
            green_cnt <= '0;
            blue_cnt  <= '0;
            clear_cnt <= '0;
        end else if (r_state == ST_STORE && !abort) begin
            unique case (r_idx)
                2'd0: red_cnt   <= r_cnt;
                2'd1: green_cnt <= r_cnt;
                2'd2: blue_cnt  <= r_cnt;
                default: clear_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_color_sensor_sequencer.sv
// Bench for color_sensor_sequencer: table-driven and random runs against
// an edge-timestamp reference model, plus abort/reset corner sequences.
module tb_color_sensor_sequencer;

    localparam int GB   = 100;
    localparam int SB   = 4;
    localparam int WB   = 5;
    localparam int MAXB = (1 << WB) - 1;
    localparam int LB   = 4 * (SB + GB + 1) + 1;
    localparam int GD   = 1000;
    localparam int SD   = 4;
    localparam int LD   = 4 * (SD + GD + 1) + 1;

    logic clk, rst_n, start, abort, freq_in;
    logic [1:0] mode;
    logic b_s0, b_s1, b_s2, b_s3, b_busy, b_done, b_ovf;
    logic [WB-1:0] b_r, b_g, b_b, b_c;
    logic d_start, d_abort;
    logic [1:0] d_mode;
    logic d_s0, d_s1, d_s2, d_s3, d_busy, d_done, d_ovf;
    logic [15:0] d_r, d_g, d_b, d_c;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int fk = 0;
    int per = 2;
    int edges[$];
    int exp_res[4];
    logic [1:0] codes[4];

    typedef struct {
        logic [1:0] mode;
        int         fk;
        int         per;
        bit         noisy;
        logic [1:0] exp_s0s1;
    } vec_t;

    color_sensor_sequencer #(.GATE_CYCLES(GB), .SETTLE_CYCLES(SB), .CNT_W(WB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
        .freq_in(freq_in), .s0(b_s0), .s1(b_s1), .s2(b_s2), .s3(b_s3),
        .busy(b_busy), .done(b_done), .overflow(b_ovf),
        .red_cnt(b_r), .green_cnt(b_g), .blue_cnt(b_b), .clear_cnt(b_c)
    );

    color_sensor_sequencer dut_d (
        .clk(clk), .rst_n(rst_n), .start(d_start), .mode(d_mode), .abort(d_abort),
        .freq_in(freq_in), .s0(d_s0), .s1(d_s1), .s2(d_s2), .s3(d_s3),
        .busy(d_busy), .done(d_done), .overflow(d_ovf),
        .red_cnt(d_r), .green_cnt(d_g), .blue_cnt(d_b), .clear_cnt(d_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sensor stimulus: 0 = stuck low, 1 = periodic, 2 = random.
    always @(negedge clk) begin
        logic nv;
        case (fk)
            1:       nv = ((cyc % per) < (per / 2));
            2:       nv = 1'($urandom_range(0, 1));
            default: nv = 1'b0;
        endcase
        if (nv && !freq_in) edges.push_back(cyc);
        freq_in = nv;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Pin edge in cycle n is detected in cycle n+2; count those in [gs,ge].
    function automatic int edges_in(input int gs, input int ge);
        int n = 0;
        foreach (edges[i])
            if (edges[i] + 2 >= gs && edges[i] + 2 <= ge) n++;
        return n;
    endfunction

    function automatic int gate_start(input int c, input int k, input int s, input int g);
        return c + s + 1 + k * (s + g + 1);
    endfunction

    task automatic chk_results(input string tag);
        chk({tag, "_red"}, int'(b_r), exp_res[0]);
        chk({tag, "_green"}, int'(b_g), exp_res[1]);
        chk({tag, "_blue"}, int'(b_b), exp_res[2]);
        chk({tag, "_clear"}, int'(b_c), exp_res[3]);
    endtask

    task automatic run_b(input logic [1:0] m, input bit noisy, input logic [1:0] xs);
        int c, drel, ndone, n, gs;
        bit ovf;
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        c     = cyc;
        drel  = -1;
        ndone = 0;
        for (int t = 1; t <= LB + 6; t++) begin
            @(negedge clk);
            start = noisy && (t == 30 || t == 200);
            mode  = start ? 2'b01 : m;
            if (t == 1) chk("ovf_clear_at_start", int'(b_ovf), 0);
            for (int k = 0; k < 4; k++)
                if (t == 1 + k * (SB + GB + 1)) begin
                    chk("filter_code", int'({b_s2, b_s3}), int'(codes[k]));
                    chk("scale_busy", int'({b_s0, b_s1}), int'(xs));
                    chk("busy_hi", int'(b_busy), 1);
                end
            if (t == LB) begin
                chk("busy_lo_done", int'(b_busy), 0);
                chk("scale_off_done", int'({b_s0, b_s1}), 0);
            end
            if (b_done) begin
                ndone++;
                if (drel < 0) drel = t;
            end
        end
        chk("done_cycle", drel, LB);
        chk("done_pulses", ndone, 1);
        ovf = 1'b0;
        for (int k = 0; k < 4; k++) begin
            gs = gate_start(c, k, SB, GB);
            n  = edges_in(gs, gs + GB - 1);
            if (n > MAXB) begin
                ovf = 1'b1;
                n   = MAXB;
            end
            exp_res[k] = n;
        end
        chk_results("run");
        chk("overflow", int'(b_ovf), int'(ovf));
    endtask

    initial begin
        vec_t tbl[5];
        int c, n, nd, gs, drel;
        codes = '{2'b00, 2'b11, 2'b01, 2'b10};
        tbl = '{
            '{2'b11, 1, 10, 1'b0, 2'b11},
            '{2'b01, 0, 2,  1'b0, 2'b01},
            '{2'b10, 1, 2,  1'b0, 2'b10},
            '{2'b01, 0, 2,  1'b0, 2'b01},
            '{2'b11, 2, 2,  1'b1, 2'b11}
        };
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'b00;
        d_start = 1'b0; d_abort = 1'b0; d_mode = 2'b11;
        freq_in = 1'b0;
        exp_res = '{0, 0, 0, 0};
        repeat (3) @(negedge clk);
        chk("rst_outputs", int'({b_s0, b_s1, b_s2, b_s3, b_busy, b_done, b_ovf}), 0);
        chk_results("rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            fk  = tbl[i].fk;
            per = tbl[i].per;
            run_b(tbl[i].mode, tbl[i].noisy, tbl[i].exp_s0s1);
        end

        for (int i = 0; i < 3; i++) begin
            logic [1:0] m;
            m   = 2'($urandom_range(1, 3));
            fk  = int'($urandom_range(1, 2));
            per = int'($urandom_range(2, 12));
            run_b(m, 1'b0, m);
        end

        // Invalid mode and abort colliding with start: no run.
        @(negedge clk);
        start = 1'b1; mode = 2'b00;
        @(negedge clk);
        start = 1'b0;
        chk("mode00_busy", int'(b_busy), 0);
        chk("mode00_scale", int'({b_s0, b_s1}), 0);
        start = 1'b1; abort = 1'b1; mode = 2'b11;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", int'(b_busy), 0);
        repeat (5) @(negedge clk);
        chk("abort_start_idle", int'(b_busy | b_done), 0);

        // Abort in green gate: red refreshed, others kept, no done.
        fk = 1; per = 6;
        @(negedge clk);
        start = 1'b1; mode = 2'b11; c = cyc;
        for (int t = 1; t <= 130; t++) begin
            @(negedge clk);
            start = 1'b0;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", int'(b_busy), 0);
        chk("abort_scale", int'({b_s0, b_s1}), 0);
        nd = 0;
        for (int t = 0; t < 450; t++) begin
            @(negedge clk);
            if (b_done) nd++;
        end
        chk("abort_no_done", nd, 0);
        gs = gate_start(c, 0, SB, GB);
        n  = edges_in(gs, gs + GB - 1);
        exp_res[0] = (n > MAXB) ? MAXB : n;
        chk_results("abort");

        // Asynchronous reset in the middle of a gate window.
        fk = 2;
        @(negedge clk);
        start = 1'b1; mode = 2'b10;
        for (int t = 1; t <= SB + 31; t++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        exp_res = '{0, 0, 0, 0};
        chk("midrst_outputs", int'({b_s0, b_s1, b_s2, b_s3, b_busy, b_done, b_ovf}), 0);
        chk_results("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        fk = 1; per = 8;
        run_b(2'b01, 1'b0, 2'b01);

        // Default-parameter instance: full-length run, period 10.
        fk = 1; per = 10;
        @(negedge clk);
        d_start = 1'b1; c = cyc; drel = -1;
        for (int t = 1; t <= LD + 4; t++) begin
            @(negedge clk);
            d_start = 1'b0;
            for (int k = 0; k < 4; k++)
                if (t == 1 + k * (SD + GD + 1)) begin
                    chk("d_filter", int'({d_s2, d_s3}), int'(codes[k]));
                    chk("d_scale", int'({d_s0, d_s1}), 3);
                end
            if (d_done && drel < 0) drel = t;
        end
        chk("d_done_cycle", drel, LD);
        gs = gate_start(c, 0, SD, GD);
        chk("d_red", int'(d_r), edges_in(gs, gs + GD - 1));
        gs = gate_start(c, 1, SD, GD);
        chk("d_green", int'(d_g), edges_in(gs, gs + GD - 1));
        gs = gate_start(c, 2, SD, GD);
        chk("d_blue", int'(d_b), edges_in(gs, gs + GD - 1));
        gs = gate_start(c, 3, SD, GD);
        chk("d_clear", int'(d_c), edges_in(gs, gs + GD - 1));
        chk("d_clear_near100", int'(d_c >= 16'd99 && d_c <= 16'd101), 1);
        chk("d_overflow", int'(d_ovf), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
